l1_snoop_responder: RTL

L1_SNOOP_RESPONDER -- requirements
Module: l1_snoop_responder

---
 rtl/l1_snoop_responder_pkg.sv | 29 ++
 rtl/l1_snoop_responder.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/l1_snoop_responder_pkg.sv
// Shared coherence package: MESI encoding, snoop responder FSM states,
// block-offset constants and the supplier-state test used by the L1 snoop path.
package l1_snoop_responder_pkg;

  typedef enum logic [1:0] {
    MESI_I = 2'd0,
    MESI_S = 2'd1,
    MESI_E = 2'd2,
    MESI_M = 2'd3
  } mesi_state_t;

  typedef enum logic [2:0] {
    SR_IDLE    = 3'd0,
    SR_LOOKUP  = 3'd1,
    SR_FETCH1  = 3'd2,
    SR_RESPOND = 3'd3,
    SR_UPDATE  = 3'd4
  } snoop_resp_state_t;

  // Snoop addresses are block aligned: 2 words x 4 bytes -> 3 offset bits.
  localparam int          BLK_OFF_W    = 3;
  localparam logic [31:0] BLK_OFF_MASK = (32'd1 << BLK_OFF_W) - 32'd1;

  // A supplier state means this cache forwards the block to the requester.
  function automatic logic is_supplier(input mesi_state_t s, input logic shared_en);
    return (s == MESI_M) || (s == MESI_E) || (shared_en && (s == MESI_S));
  endfunction

endpackage

// File: rtl/l1_snoop_responder.sv
// L1 snoop responder: looks up a snooped block, reports hit/present/dirty,
// supplies the two-word block when the line is in a supplier state, and
// downgrades (S) or invalidates (I) the line once the snoop completes.
// Build option: define SNOOP_SHARED_SUPPLY_EN to let S-state lines supply data.
module l1_snoop_responder
  import l1_snoop_responder_pkg::*;
#(
  parameter int BLOCK_SIZE = 2
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        ccwait,
  input  logic        ccinv,
  input  logic [31:0] ccsnoopaddr,
  input  logic        bus_xfer,
  output logic        ccsnoopdone,
  output logic        ccsnoophit,
  output logic        ccIsPresent,
  output logic        ccdirty,
  output logic [31:0] dstore,
  output logic        snp_req,
  output logic [31:0] snp_addr,
  output logic        snp_word_sel,
  input  logic        snp_ack,
  input  logic [1:0]  snp_state,
  input  logic [31:0] snp_rdata,
  output logic        snp_upd,
  output logic [1:0]  snp_new_state
);

`ifdef SNOOP_SHARED_SUPPLY_EN
  localparam logic SHARED_SUPPLY = 1'b1;
`else
  localparam logic SHARED_SUPPLY = 1'b0;
`endif

  localparam logic LAST_BEAT = 1'(BLOCK_SIZE - 1);

  snoop_resp_state_t state_r, state_nxt;
  logic [31:0]       addr_r;
  logic              inv_r;
  mesi_state_t       st_r;
  logic [31:0]       word0, word1;
  logic              beat_r;
  logic              st_sup;
  mesi_state_t       look_st;

  assign st_sup  = is_supplier(st_r, SHARED_SUPPLY);
  assign look_st = mesi_state_t'(snp_state);

  // FSM state register.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) state_r <= SR_IDLE;
    else       state_r <= state_nxt;
  end

  // Snoop context and two-word block buffer, loaded as the lookup progresses.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      addr_r <= '0;
      inv_r  <= 1'b0;
      st_r   <= MESI_I;
      word0  <= '0;
      word1  <= '0;
      beat_r <= 1'b0;
    end else begin
      case (state_r)
        SR_IDLE: begin
          if (ccwait) begin
            addr_r <= ccsnoopaddr & ~BLK_OFF_MASK;
            inv_r  <= ccinv;
            beat_r <= 1'b0;
          end
        end
        SR_LOOKUP: begin
          if (ccwait && snp_ack) begin
            st_r  <= look_st;
            word0 <= snp_rdata;
          end
        end
        SR_FETCH1: begin
          if (ccwait && snp_ack) word1 <= snp_rdata;
        end
        SR_RESPOND: begin
          if (bus_xfer && st_sup) beat_r <= (beat_r == LAST_BEAT) ? 1'b0 : beat_r + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Next-state decode and Moore outputs; anything not driven by a state stays 0.
  always_comb begin
    state_nxt     = state_r;
    ccsnoopdone   = 1'b0;
    ccsnoophit    = 1'b0;
    ccIsPresent   = 1'b0;
    ccdirty       = 1'b0;
    dstore        = '0;
    snp_req       = 1'b0;
    snp_addr      = '0;
    snp_word_sel  = 1'b0;
    snp_upd       = 1'b0;
    snp_new_state = MESI_I;
    case (state_r)
      SR_IDLE: begin
        if (ccwait) state_nxt = SR_LOOKUP;
      end
      SR_LOOKUP: begin
        snp_req  = 1'b1;
        snp_addr = addr_r;
        if (!ccwait)
          state_nxt = SR_IDLE;
        else if (snp_ack)
          state_nxt = is_supplier(look_st, SHARED_SUPPLY) ? SR_FETCH1 : SR_RESPOND;
      end
      SR_FETCH1: begin
        snp_req      = 1'b1;
        snp_addr     = addr_r + 32'd4;
        snp_word_sel = 1'b1;
        if (!ccwait)      state_nxt = SR_IDLE;
        else if (snp_ack) state_nxt = SR_RESPOND;
      end
      SR_RESPOND: begin
        ccsnoopdone = 1'b1;
        ccsnoophit  = st_sup;
        ccIsPresent = (st_r != MESI_I);
        ccdirty     = (st_r == MESI_M);
        // Non-supplier lines put nothing on the data bus.
        if (st_sup) dstore = beat_r ? word1 : word0;
        if (!ccwait) state_nxt = (st_r != MESI_I) ? SR_UPDATE : SR_IDLE;
      end
      SR_UPDATE: begin
        snp_upd       = 1'b1;
        snp_addr      = addr_r;
        snp_new_state = inv_r ? MESI_I : MESI_S;
        state_nxt     = SR_IDLE;
      end
      default: state_nxt = SR_IDLE;
    endcase
  end

endmodule
